// File: rtl/exc_pkg.sv
// exc_pkg: shared state encoding and cause codes for the exception/interrupt sequencer
// Contents: state_e (IDLE, REQ, HANDLER), ESTAT_* cause codes, MAX_IRQ source limit.
package exc_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_e;
  localparam logic [3:0] ESTAT_NONE  = 4'b0000;
  localparam logic [3:0] ESTAT_INVOP = 4'b0010;
  localparam logic [3:0] ESTAT_IRQ   = 4'b1000;
  localparam int MAX_IRQ = 8;
endpackage

// File: rtl/prio_enc_lsb.sv
// prio_enc_lsb: combinational priority encoder, lowest set index wins
// Ports: req (W request bits) -> valid (any set), idx (lowest set index).
module prio_enc_lsb #(
  parameter int W = 4
) (
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) idx = req[i] ? 3'(i) : idx;
  end
endmodule

// File: rtl/exc_irq_ctrl.sv
// exc_irq_ctrl: arbitrates invalid-opcode and edge-latched IRQ causes into the core's Exc/EStatus handshake
// Ports: clk, reset (async, active-low); irq_req, inv_op, ExcAck, ERet in;
//        Exc, EStatus, ExtIAck, pending, in_handler, timeout_err out.
// Optional: define EXC_TIMEOUT_EN to abandon a request after TIMEOUT cycles without ExcAck.
module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               inv_op,
  input  logic               ExcAck,
  input  logic               ERet,
  output logic               Exc,
  output logic [3:0]         EStatus,
  output logic [NUM_IRQ-1:0] ExtIAck,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_handler,
  output logic               timeout_err
);
  if (NUM_IRQ < 1 || NUM_IRQ > MAX_IRQ || TIMEOUT < 1) begin : g_bad_param
    $error("exc_irq_ctrl: unsupported NUM_IRQ or TIMEOUT");
  end
  state_e state_q, state_d;
  logic [3:0] cause_q, cause_d;
  logic exc_q, exc_d, in_handler_q, in_handler_d, armed_q;
  logic [NUM_IRQ-1:0] irq_prev_q, pending_q, pending_d, ack_q, ack_d, rise;
  logic pend_vld;
  logic [2:0] pend_idx;
`ifdef EXC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic terr_q, terr_d;
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif
  prio_enc_lsb #(.W(NUM_IRQ)) u_prio (.req(pending_q), .valid(pend_vld), .idx(pend_idx));
  // The first sample after reset only seeds the history, so a line already high
  // when reset is released is not mistaken for a fresh edge.
  assign rise = irq_req & ~irq_prev_q & {NUM_IRQ{armed_q}};
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    exc_d = exc_q;
    in_handler_d = in_handler_q;
    ack_d = '0;
`ifdef EXC_TIMEOUT_EN
    cnt_d = '0;
    terr_d = terr_q;
`endif
    case (state_q)
      IDLE: begin
        if (inv_op) begin
          state_d = REQ;
          cause_d = ESTAT_INVOP;
          exc_d = 1'b1;
        end else if (pend_vld) begin
          state_d = REQ;
          cause_d = ESTAT_IRQ | {1'b0, pend_idx};
          exc_d = 1'b1;
        end
      end
      REQ: begin
        if (ExcAck) begin
          state_d = HANDLER;
          exc_d = 1'b0;
          in_handler_d = 1'b1;
          ack_d = cause_q[3] ? NUM_IRQ'(1) << cause_q[2:0] : '0;
        end
`ifdef EXC_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          exc_d = 1'b0;
          cause_d = ESTAT_NONE;
          terr_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
`endif
      end
      HANDLER: begin
        if (ERet) begin
          state_d = IDLE;
          cause_d = ESTAT_NONE;
          in_handler_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge on the bit being acknowledged must survive the clear.
    pending_d = (pending_q & ~ack_d) | rise;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cause_q <= ESTAT_NONE;
      exc_q <= 1'b0;
      in_handler_q <= 1'b0;
      ack_q <= '0;
      pending_q <= '0;
      irq_prev_q <= '0;
      armed_q <= 1'b0;
`ifdef EXC_TIMEOUT_EN
      cnt_q <= '0;
      terr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      exc_q <= exc_d;
      in_handler_q <= in_handler_d;
      ack_q <= ack_d;
      pending_q <= pending_d;
      irq_prev_q <= irq_req;
      armed_q <= 1'b1;
`ifdef EXC_TIMEOUT_EN
      cnt_q <= cnt_d;
      terr_q <= terr_d;
`endif
    end
  end
  assign Exc = exc_q;
  assign EStatus = cause_q;
  assign ExtIAck = ack_q;
  assign pending = pending_q;
  assign in_handler = in_handler_q;
endmodule
